// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD bypassing read ports, a
// per-register pending scoreboard and a bulk-clear sweep FSM.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  set_busy,
  input  logic [ADDR_W-1:0]     set_addr,
  output logic [NRD-1:0]        rbusy,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  ptr, ptr_n;
  logic               done_n;

  logic [DATA_W-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]   busy;

  logic clearing;
  logic wen0, wen1, sbusy;

  // Register 0 is hardwired: any write or busy-set aimed at it is dropped.
  assign clearing = (state == CLEAR);
  assign wen0     = we0 && !clearing && (waddr0 != '0);
  assign wen1     = we1 && !clearing && (waddr1 != '0);
  assign sbusy    = set_busy && !clearing && (set_addr != '0);
  assign clr_busy = clearing;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
          ptr_n   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          ptr_n = ptr + ADDR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      clr_done <= done_n;
    end
  end

  // Port 1 is applied after port 0 so it wins on a shared address; a
  // busy-set is applied after the write-clears so it wins the race too.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else if (clearing) begin
      regs[ptr] <= '0;
      busy[ptr] <= 1'b0;
    end else begin
      if (wen0) begin
        regs[waddr0] <= wdata0;
        busy[waddr0] <= 1'b0;
      end
      if (wen1) begin
        regs[waddr1] <= wdata1;
        busy[waddr1] <= 1'b0;
      end
      if (sbusy) busy[set_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              en, h0, h1;

    assign ra = raddr[p*ADDR_W +: ADDR_W];
    assign en = re[p] && !rst && !clearing && (ra != '0);
    assign h0 = wen0 && (waddr0 == ra);
    assign h1 = wen1 && (waddr1 == ra);

    // Same-cycle write data is forwarded so a reader never sees stale data.
    assign rdata[p*DATA_W +: DATA_W] = !en ? '0 :
                                       h1  ? wdata1 :
                                       h0  ? wdata0 : regs[ra];
    assign rbusy[p] = en && busy[ra] && !h0 && !h1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp (NRD=4, DATA_W=64) against an
// array-based behavioural model.
module tb_regfile_mp;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic              rst, we0, we1, set_busy, clr_req;
  logic [AW-1:0]     waddr0, waddr1, set_addr;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NR-1:0]     re;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              clr_busy, clr_done;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .set_busy(set_busy), .set_addr(set_addr), .rbusy(rbusy),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  // Reference model: plain arrays plus a count of sweep cycles remaining.
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy[DEPTH];
  int            m_left = 0;
  bit            m_done = 0;

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rb;
    logic             cb;
    logic             cd;
    string            tag;
  } exp_t;

  exp_t  q[$];
  exp_t  me;
  int    checks = 0;
  int    failures = 0;
  string tag = "init";

  function automatic exp_t predict();
    exp_t          e;
    logic [AW-1:0] a;
    bit            h0, h1;
    e.rd  = '0;
    e.rb  = '0;
    e.cb  = (m_left > 0);
    e.cd  = m_done;
    e.tag = tag;
    if (!rst && m_left == 0) begin
      for (int p = 0; p < NR; p++) begin
        a = raddr[p*AW +: AW];
        if (re[p] && a != 0) begin
          h0 = we0 && (waddr0 == a);
          h1 = we1 && (waddr1 == a);
          e.rd[p*DW +: DW] = h1 ? wdata1 : (h0 ? wdata0 : m_reg[a]);
          e.rb[p] = m_busy[a] && !h0 && !h1;
        end
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 0;
      end
      m_left = 0;
      m_done = 0;
    end else if (m_left > 0) begin
      m_reg[DEPTH - m_left]  = '0;
      m_busy[DEPTH - m_left] = 0;
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 0;
      if (we0 && waddr0 != 0) begin m_reg[waddr0] = wdata0; m_busy[waddr0] = 0; end
      if (we1 && waddr1 != 0) begin m_reg[waddr1] = wdata1; m_busy[waddr1] = 0; end
      if (set_busy && set_addr != 0) m_busy[set_addr] = 1;
      if (clr_req) m_left = DEPTH - 1;
    end
  endtask

  task automatic cycle(input bit chk = 1);
    if (chk) q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; we0 = 0; we1 = 0; set_busy = 0; clr_req = 0;
    waddr0 = '0; waddr1 = '0; set_addr = '0;
    wdata0 = '0; wdata1 = '0; re = '0; raddr = '0;
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1'b1;
    raddr[p*AW +: AW] = a[AW-1:0];
  endtask

  function automatic logic [AW-1:0] raddr_rand();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction

  function automatic logic [DW-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: outputs are combinational, so every cycle is a presentation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rdata[p*DW +: DW] !== me.rd[p*DW +: DW]) begin
          failures++;
          $display("FAIL %s rdata[%0d] got=%h exp=%h", me.tag, p, rdata[p*DW +: DW], me.rd[p*DW +: DW]);
        end
      end
      checks++;
      if (rbusy !== me.rb) begin
        failures++;
        $display("FAIL %s rbusy got=%b exp=%b", me.tag, rbusy, me.rb);
      end
      checks++;
      if (clr_busy !== me.cb) begin
        failures++;
        $display("FAIL %s clr_busy got=%b exp=%b", me.tag, clr_busy, me.cb);
      end
      checks++;
      if (clr_done !== me.cd) begin
        failures++;
        $display("FAIL %s clr_done got=%b exp=%b", me.tag, clr_done, me.cd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1; cycle(0);
    tag = "reset"; cycle();

    idle(); tag = "v1_write";
    we0 = 1; waddr0 = 5; wdata0 = 64'hDEADBEEF; cycle();
    idle(); tag = "v1_read"; rd(1, 5); rd(0, 0); cycle();

    idle(); tag = "v2_bypass";
    we0 = 1; waddr0 = 7; wdata0 = 64'h11;
    we1 = 1; waddr1 = 7; wdata1 = 64'h22;
    rd(0, 7); rd(2, 7); cycle();
    idle(); tag = "v2_after"; rd(3, 7); cycle();

    idle(); tag = "v3_set"; set_busy = 1; set_addr = 9; cycle();
    idle(); tag = "v3_busy"; rd(0, 9); cycle();
    tag = "v3_wr_bypass"; we0 = 1; waddr0 = 9; wdata0 = 64'h5; cycle();
    idle(); tag = "v3_cleared"; rd(0, 9); cycle();

    idle(); tag = "busy_wins";
    set_busy = 1; set_addr = 12; we1 = 1; waddr1 = 12; wdata1 = 64'hA5A5_0000_1234_5678;
    rd(1, 12); cycle();
    idle(); tag = "busy_wins_after"; rd(1, 12); cycle();

    idle(); tag = "r0_write";
    we0 = 1; waddr0 = 0; wdata0 = '1; set_busy = 1; set_addr = 0;
    rd(0, 0); cycle();
    idle(); tag = "r0_read"; for (int p = 0; p < NR; p++) rd(p, 0); cycle();

    idle(); tag = "v6_fill";
    we0 = 1; waddr0 = 3;  wdata0 = rand64();
    we1 = 1; waddr1 = 4;  wdata1 = rand64(); cycle();
    waddr0 = 20; wdata0 = rand64(); waddr1 = 31; wdata1 = rand64(); cycle();
    idle(); tag = "v6_read4"; rd(0, 3); rd(1, 4); rd(2, 20); rd(3, 31); cycle();

    for (int n = 0; n < 400; n++) begin
      idle(); tag = "random";
      rst      = ($urandom_range(0, 99) == 0);
      we0      = $urandom_range(0, 1); waddr0 = raddr_rand(); wdata0 = rand64();
      we1      = $urandom_range(0, 1); waddr1 = raddr_rand(); wdata1 = rand64();
      set_busy = ($urandom_range(0, 3) == 0); set_addr = raddr_rand();
      clr_req  = ($urandom_range(0, 99) == 0);
      re       = NR'($urandom_range(0, 15));
      for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = raddr_rand();
      cycle();
    end

    idle(); rst = 1; tag = "v4_reset"; cycle();
    idle(); tag = "v4_fill";
    for (int i = 1; i < DEPTH; i += 2) begin
      we0 = 1; waddr0 = AW'(i); wdata0 = rand64() | 64'h1;
      we1 = (i + 1 < DEPTH); waddr1 = AW'((i + 1) % DEPTH); wdata1 = rand64() | 64'h1;
      set_busy = 1; set_addr = AW'(i);
      cycle();
    end
    idle(); tag = "v4_start"; clr_req = 1; cycle();
    for (int k = 0; k < 33; k++) begin
      idle(); tag = "v4_sweep";
      for (int p = 0; p < NR; p++) rd(p, $urandom_range(1, 31));
      if (k == 10) begin
        we0 = 1; waddr0 = 2; wdata0 = 64'hBAD;
        set_busy = 1; set_addr = 25; clr_req = 1;
      end
      cycle();
    end
    for (int a = 0; a < DEPTH; a += NR) begin
      idle(); tag = "v4_readback";
      for (int p = 0; p < NR; p++) rd(p, a + p);
      cycle();
    end

    idle(); tag = "v5_fill";
    we0 = 1; waddr0 = 6; wdata0 = rand64(); we1 = 1; waddr1 = 30; wdata1 = rand64(); cycle();
    idle(); tag = "v5_start"; clr_req = 1; cycle();
    for (int k = 0; k < 10; k++) begin
      idle(); tag = "v5_sweep"; rd(0, 30); cycle();
    end
    idle(); tag = "v5_rst"; rst = 1; rd(0, 30); rd(1, 6); cycle();
    idle(); tag = "v5_write"; we0 = 1; waddr0 = 5; wdata0 = 64'h0123_4567_89AB_CDEF;
    rd(0, 5); rd(1, 30); cycle();
    idle(); tag = "v5_after"; rd(2, 5); rd(3, 6); cycle();

    idle(); tag = "drain"; cycle();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain queue_left got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 2, number of read ports (legal range 1..4).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 we0, we1  in  1 each  write enables, ports 0 and 1.
REQ-007 waddr0, waddr1  in  ADDR_W each  write addresses.
REQ-008 wdata0, wdata1  in  DATA_W each  write data.
REQ-009 re  in  NRD  per-port read enables.
REQ-010 raddr  in  NRD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-011 rdata  out  NRD*DATA_W  read data, combinational; port p occupies bits [p*DATA_W +: DATA_W].
REQ-012 set_busy  in  1  mark register set_addr pending, e.g. for an outstanding load.
REQ-013 set_addr  in  ADDR_W  scoreboard set address.
REQ-014 rbusy  out  NRD  per-port pending flag for raddr, combinational.
REQ-015 clr_req  in  1  start bulk-clear sweep.
REQ-016 clr_busy  out  1  sweep in progress.
REQ-017 clr_done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-018 Register 0 SHALL always read 0 and never be busy; writes and set_busy to address 0 are discarded.
REQ-019 Writes SHALL commit at the rising edge; both ports may write different addresses in the same cycle.
REQ-020 When we0 and we1 target the same address, port 1 data SHALL win.
REQ-021 Read port p SHALL return 0 when re[p]=0 or raddr_p=0.
REQ-022 Otherwise, if the address matches an enabled write port in the same cycle, read port p SHALL return that write data (same-cycle bypass); port 1 wins over port 0.
REQ-023 Otherwise, read port p SHALL return the stored value.
REQ-024 set_busy SHALL set busy[set_addr] at the edge; a write to an address SHALL clear its busy bit at the edge.
REQ-025 If set_busy and a write hit the same address in the same cycle, set_busy SHALL win and the bit ends at 1; the write data is still stored.
REQ-026 rbusy[p] = re[p] and busy[raddr_p], forced to 0 when an enabled write to raddr_p is present in the same cycle.
REQ-027 FSM states: IDLE and CLEAR, with an ADDR_W-bit sweep pointer ptr.
REQ-028 In IDLE, clr_req=1 SHALL load ptr=1 and move the FSM to CLEAR.
REQ-029 In CLEAR, each edge SHALL zero regs[ptr] and busy[ptr] and increment ptr.
REQ-030 In CLEAR, the FSM SHALL return to IDLE on the edge where ptr = DEPTH-1; that sweep takes DEPTH-1 cycles.
REQ-031 clr_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-032 clr_done SHALL be registered and high for the single cycle after the return to IDLE.
REQ-033 While clr_busy=1, writes, set_busy and clr_req SHALL be ignored, all rdata SHALL read 0, and all rbusy SHALL read 0.
REQ-034 When ptr reaches DEPTH-1 it SHALL NOT wrap to 0 during the sweep.

Reset
REQ-035 With rst=1 at an edge: all registers and busy bits SHALL be zeroed, FSM -> IDLE, ptr=0, clr_done=0.
REQ-036 Reset SHALL take priority over every other input, including a sweep in progress.
REQ-037 While rst=1, all rdata and rbusy SHALL read 0.

Verification
V1 Write 0xDEADBEEF to r5 via we0; next cycle read r5 on port 1 -> 0xDEADBEEF; read r0 -> 0.
V2 we0 and we1 both write r7 (0x11, 0x22) with a same-cycle read of r7 -> rdata 0x22 (bypass); next cycle r7 -> 0x22.
V3 set_busy r9 -> rbusy=1 next cycle; then wdata 0x5 to r9 with a same-cycle read -> rbusy=0, rdata 0x5; next cycle busy bit clear.
V4 Fill r1..r31 with nonzero data, pulse clr_req -> clr_busy high 31 cycles, clr_done pulse on cycle 32, all registers then read 0; a we0 issued mid-sweep has no effect.
V5 Assert rst mid-sweep -> next cycle clr_busy=0, clr_done=0, all registers 0; new writes accepted immediately.
V6 Parameters NRD=4, DATA_W=64: four simultaneous reads of distinct registers return the correct 64-bit values.
